clock_step_controller: RTL and testbench

Run/single-step controller placed directly upstream of the CPU clock divider; it generates the divider's `halt` input. It debounces the board's run switch and step push-button, lets the divided CPU clock free-run or advance exactly one rising edge per button press, and freezes the clock permanently when the CPU signals a stop. It watches the divider's output clock to decide when a step is complete.

---
 rtl/clock_step_controller_pkg.sv | 10 +
 rtl/input_debouncer.sv | 28 ++
 rtl/clock_step_controller.sv | 81 ++++++++
 tb/tb_clock_step_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/clock_step_controller_pkg.sv
// clock_step_controller_pkg: shared FSM state encoding and step counter width
package clock_step_controller_pkg;
   localparam int STEP_COUNT_W = 16;
   typedef enum logic [1:0] {
      HALTED  = 2'd0,
      RUN     = 2'd1,
      STEP    = 2'd2,
      STOPPED = 2'd3
   } state_t;
endpackage

// File: rtl/input_debouncer.sv
// input_debouncer: 2-FF synchronizer followed by a level debouncer
module input_debouncer #(
   parameter logic [27:0] DEBOUNCE_CYCLES = 28'd1_000_000
) (
   input  logic input_clock,
   input  logic reset,
   input  logic raw,
   output logic level
);
   logic [1:0]  sync;
   logic [27:0] count;
   // the new level is taken on the edge that completes DEBOUNCE_CYCLES differing samples
   always_ff @(posedge input_clock or posedge reset)
      if (reset) begin
         sync  <= 2'b00;
         count <= '0;
         level <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         if (sync[1] == level)
            count <= '0;
         else if (count == DEBOUNCE_CYCLES - 28'd1) begin
            level <= sync[1];
            count <= '0;
         end else
            count <= count + 28'd1;
      end
endmodule

// File: rtl/clock_step_controller.sv
// clock_step_controller: run/single-step control of the CPU clock divider halt input
module clock_step_controller
   import clock_step_controller_pkg::*;
#(
   parameter logic [27:0] DEBOUNCE_CYCLES = 28'd1_000_000
) (
   input  logic                    input_clock,
   input  logic                    reset,
   input  logic                    run_switch,
   input  logic                    step_button,
   input  logic                    cpu_stop,
   input  logic                    divided_clock,
   output logic                    halt,
   output logic                    stopped,
   output logic [STEP_COUNT_W-1:0] step_count
);
   logic   run_level, step_level, step_prev, clock_prev, press, clk_rise;
   state_t state;
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) run_debouncer (
      .input_clock(input_clock),
      .reset(reset),
      .raw(run_switch),
      .level(run_level)
   );
   input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) step_debouncer (
      .input_clock(input_clock),
      .reset(reset),
      .raw(step_button),
      .level(step_level)
   );
   assign press    = step_level & ~step_prev;
   assign clk_rise = divided_clock & ~clock_prev;
   // a step still counts when cpu_stop coincides with its completing clock edge
   always_ff @(posedge input_clock or posedge reset)
      if (reset) begin
         state      <= HALTED;
         halt       <= 1'b1;
         stopped    <= 1'b0;
         step_count <= '0;
         step_prev  <= 1'b0;
         clock_prev <= 1'b0;
      end else begin
         step_prev  <= step_level;
         clock_prev <= divided_clock;
         case (state)
            HALTED:
               if (cpu_stop) begin
                  state   <= STOPPED;
                  stopped <= 1'b1;
               end else if (run_level) begin
                  state <= RUN;
                  halt  <= 1'b0;
               end else if (press) begin
                  state <= STEP;
                  halt  <= 1'b0;
               end
            RUN:
               if (cpu_stop) begin
                  state   <= STOPPED;
                  halt    <= 1'b1;
                  stopped <= 1'b1;
               end else if (!run_level) begin
                  state <= HALTED;
                  halt  <= 1'b1;
               end
            STEP: begin
               if (clk_rise)
                  step_count <= step_count + STEP_COUNT_W'(1);
               if (cpu_stop) begin
                  state   <= STOPPED;
                  halt    <= 1'b1;
                  stopped <= 1'b1;
               end else if (clk_rise) begin
                  state <= HALTED;
                  halt  <= 1'b1;
               end
            end
            STOPPED: ;
         endcase
      end
endmodule

// File: tb/tb_clock_step_controller.sv
// tb_clock_step_controller: random and directed stimulus checked against a behavioural model
module tb_clock_step_controller;
   import clock_step_controller_pkg::*;
   localparam int N = 4;
   logic        input_clock = 1'b0, reset = 1'b1, run_switch = 1'b0, step_button = 1'b0, cpu_stop = 1'b0;
   logic        divided_clock = 1'b0;
   logic        halt, stopped;
   logic [15:0] step_count;
   int          compared = 0, mismatched = 0;
   always #5 input_clock = ~input_clock;
   clock_step_controller #(.DEBOUNCE_CYCLES(28'd4)) dut (
      .input_clock(input_clock),
      .reset(reset),
      .run_switch(run_switch),
      .step_button(step_button),
      .cpu_stop(cpu_stop),
      .divided_clock(divided_clock),
      .halt(halt),
      .stopped(stopped),
      .step_count(step_count)
   );
   // divide-by-2 divider frozen by halt
   always @(posedge input_clock or posedge reset)
      if (reset) divided_clock <= 1'b0;
      else if (!halt) divided_clock <= ~divided_clock;
   // behavioural model: raw history decides debounced levels, mode decides halt
   state_t       m_state = HALTED;
   logic         m_run = 1'b0, m_btn = 1'b0, m_btn_prev = 1'b0, m_div_prev = 1'b0;
   logic [15:0]  m_count = 16'd0;
   logic [N+1:0] run_hist = '0, btn_hist = '0;
   task automatic model_reset();
      m_state = HALTED;
      m_run = 1'b0;
      m_btn = 1'b0;
      m_btn_prev = 1'b0;
      m_div_prev = 1'b0;
      m_count = 16'd0;
      run_hist = '0;
      btn_hist = '0;
   endtask
   task automatic model_step();
      logic press, rise;
      press = m_btn & ~m_btn_prev;
      rise  = divided_clock & ~m_div_prev;
      if (m_state != STOPPED && cpu_stop) begin
         if (m_state == STEP && rise) m_count = m_count + 16'd1;
         m_state = STOPPED;
      end else if (m_state == HALTED)
         m_state = m_run ? RUN : (press ? STEP : HALTED);
      else if (m_state == RUN) begin
         if (!m_run) m_state = HALTED;
      end else if (m_state == STEP && rise) begin
         m_count = m_count + 16'd1;
         m_state = HALTED;
      end
      m_btn_prev = m_btn;
      m_div_prev = divided_clock;
      run_hist = {run_hist[N:0], run_switch};
      btn_hist = {btn_hist[N:0], step_button};
      if (run_hist[N+1:2] == {N{~m_run}}) m_run = ~m_run;
      if (btn_hist[N+1:2] == {N{~m_btn}}) m_btn = ~m_btn;
   endtask
   always @(posedge input_clock or posedge reset)
      if (reset) model_reset();
      else model_step();
   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask
   always @(negedge input_clock) begin
      chk("halt", {15'd0, halt}, {15'd0, m_state == HALTED || m_state == STOPPED});
      chk("stopped", {15'd0, stopped}, {15'd0, m_state == STOPPED});
      chk("step_count", step_count, m_count);
   end
   task automatic cyc(input int n);
      repeat (n) @(negedge input_clock);
   endtask
   task automatic do_reset();
      @(negedge input_clock);
      #2 reset = 1'b1;
      cyc(3);
      reset = 1'b0;
   endtask
   task automatic wait_halt(input logic v, input int budget, output int n);
      n = 0;
      while (halt !== v && n < budget) begin
         @(negedge input_clock);
         n++;
      end
      if (halt !== v) chk("wait_halt_timeout", {15'd0, halt}, {15'd0, v});
   endtask
   task automatic step_press(input int hold);
      step_button = 1'b1;
      cyc(hold);
      step_button = 1'b0;
      cyc(12);
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n;
      logic [15:0] c0;
      logic d_last;
      do_reset();
      chk("reset_halt", {15'd0, halt}, 16'd1);
      chk("reset_stopped", {15'd0, stopped}, 16'd0);
      chk("reset_count", step_count, 16'd0);
      cyc(100);
      chk("idle_halt", {15'd0, halt}, 16'd1);
      run_switch = 1'b1;
      wait_halt(1'b0, 20, n);
      chk("run_latency", 16'(n), 16'd7);
      run_switch = 1'b0;
      wait_halt(1'b1, 20, n);
      chk("halt_latency", 16'(n), 16'd7);
      cyc(10);
      for (int i = 0; i < 10; i++) step_press(10);
      chk("ten_steps", step_count, 16'd10);
      for (int i = 0; i < 10; i++) begin
         step_button = (i % 2 == 0);
         cyc(2);
      end
      step_press(10);
      chk("bounce_step", step_count, 16'd11);
      for (int i = 0; i < 40; i++) begin
         run_switch = 1'($urandom_range(0, 3) == 0);
         step_button = 1'($urandom);
         cyc($urandom_range(1, 12));
      end
      run_switch = 1'b0;
      step_button = 1'b0;
      cyc(20);
      c0 = m_count;
      step_button = 1'b1;
      wait_halt(1'b0, 20, n);
      d_last = divided_clock;
      for (int i = 0; i < 10; i++) begin
         @(negedge input_clock);
         if (divided_clock && !d_last) break;
         d_last = divided_clock;
      end
      cpu_stop = 1'b1;
      @(negedge input_clock);
      cpu_stop = 1'b0;
      chk("stop_rise_stopped", {15'd0, stopped}, 16'd1);
      chk("stop_rise_count", step_count, c0 + 16'd1);
      step_button = 1'b0;
      do_reset();
      run_switch = 1'b1;
      wait_halt(1'b0, 20, n);
      cyc(3);
      cpu_stop = 1'b1;
      @(negedge input_clock);
      cpu_stop = 1'b0;
      chk("run_stop_halt", {15'd0, halt}, 16'd1);
      chk("run_stop_stopped", {15'd0, stopped}, 16'd1);
      run_switch = 1'b0;
      cyc(10);
      step_press(10);
      run_switch = 1'b1;
      cyc(10);
      chk("absorb_halt", {15'd0, halt}, 16'd1);
      chk("absorb_count", step_count, 16'd0);
      run_switch = 1'b0;
      do_reset();
      cyc(2);
      #1 force dut.step_count = 16'hFFFF;
      m_count = 16'hFFFF;
      #1 release dut.step_count;
      cyc(1);
      step_press(10);
      chk("wrap", step_count, 16'h0000);
      step_press(10);
      chk("after_wrap", step_count, 16'h0001);
      step_button = 1'b1;
      wait_halt(1'b0, 20, n);
      #2 reset = 1'b1;
      #1;
      chk("async_reset_halt", {15'd0, halt}, 16'd1);
      chk("async_reset_count", step_count, 16'd0);
      step_button = 1'b0;
      cyc(3);
      reset = 1'b0;
      cyc(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
